branch_predict_bht: RTL and testbench

Parametrised successor to the single-counter branch predictor in the fetch stage: a per-PC table of 2-bit saturating counters. The table is optionally indexed gshare-style with a global history register. Decode of conditional branches is widened to cover the REGIMM branches. The block gives a same-cycle taken/target prediction in F. It accepts a resolution update from D, and keeps branch and mispredict counters for performance debug.

---
 rtl/branch_predict_bht.sv | 121 ++++++++++++
 tb/tb_branch_predict_bht.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_bht.sv
// Fetch-stage branch predictor: a table of 2-bit saturating counters,
// indexed by PC bits and optionally XOR-folded with global history (gshare).
// Predicts taken/target in the same cycle and updates non-speculatively
// when a branch resolves in decode. Branch and mispredict counters support
// performance debug.
module branch_predict_bht #(
    parameter int         INDEX_BITS = 6,
    parameter int         GHR_BITS   = 0,
    parameter logic [1:0] CNT_INIT   = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pcF,
    input  logic [31:0]           instrF,
    output logic                  is_branchF,
    output logic                  predict_takenF,
    output logic [31:0]           pc_predictF,
    output logic [INDEX_BITS-1:0] predict_indexF,
    input  logic                  update_en,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    input  logic                  update_pred,
    output logic                  mispredictD,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    if (INDEX_BITS < 2 || INDEX_BITS > 10) begin : g_bad_index_bits
        $error("branch_predict_bht: INDEX_BITS must be in 2..10");
    end

    if (GHR_BITS < 0 || GHR_BITS > INDEX_BITS) begin : g_bad_ghr_bits
        $error("branch_predict_bht: GHR_BITS must be in 0..INDEX_BITS");
    end

    logic [5:0]            opcode;
    logic [4:0]            rt_field;
    logic                  unused_rs;
    logic [INDEX_BITS-1:0] base_index;
    logic [INDEX_BITS-1:0] read_index;
    logic [1:0]            bht [ENTRIES];

    assign opcode    = instrF[31:26];
    assign rt_field  = instrF[20:16];
    assign unused_rs = ^instrF[25:21];

    // Conditional branch decode: the four I-type compares plus the REGIMM group.
    always_comb begin
        is_branchF = 1'b0;
        case (opcode)
            6'b000100, 6'b000101, 6'b000110, 6'b000111: is_branchF = 1'b1;
            6'b000001: begin
                case (rt_field)
                    5'b00000, 5'b00001, 5'b10000, 5'b10001: is_branchF = 1'b1;
                    default: is_branchF = 1'b0;
                endcase
            end
            default: is_branchF = 1'b0;
        endcase
    end

    assign pc_predictF = pcF + 32'd4 + {{14{instrF[15]}}, instrF[15:0], 2'b00};

    assign base_index = pcF[INDEX_BITS+1:2];

    if (GHR_BITS == 0) begin : g_bimodal
        assign read_index = base_index;
    end else begin : g_gshare
        logic [GHR_BITS-1:0] ghr;

        assign read_index = base_index ^ INDEX_BITS'(ghr);

        // History shifts in the resolved outcome only; F reads the pre-shift value.
        always_ff @(posedge clk) begin
            if (reset) begin
                ghr <= '0;
            end else if (update_en) begin
                ghr <= GHR_BITS'({ghr, update_taken});
            end
        end
    end

    assign predict_indexF = read_index;
    assign predict_takenF = is_branchF & bht[read_index][1];
    assign mispredictD    = update_en & (update_taken != update_pred);

    // Counter table: saturating increment on taken, decrement on not-taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (update_en) begin
            if (update_taken) begin
                if (bht[update_index] != 2'b11) begin
                    bht[update_index] <= bht[update_index] + 2'b01;
                end
            end else begin
                if (bht[update_index] != 2'b00) begin
                    bht[update_index] <= bht[update_index] - 2'b01;
                end
            end
        end
    end

    // Performance counters: every resolved branch, and those that mispredicted.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (update_en) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredictD) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_bht.sv
// Self-checking bench for branch_predict_bht: a bimodal and a gshare (2-bit
// history) instance share stimulus; a behavioural model predicts every
// output each cycle, and directed literal checks pin the model.
module tb_branch_predict_bht;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcF = '0;
    logic [31:0] instrF = '0;
    logic        update_en = 1'b0;
    logic [5:0]  update_index = '0;
    logic        update_taken = 1'b0;
    logic        update_pred = 1'b0;

    logic        b_is_branch, b_taken, b_mispredict;
    logic [31:0] b_target, b_bcnt, b_mcnt;
    logic [5:0]  b_index;
    logic        g_is_branch, g_taken, g_mispredict;
    logic [31:0] g_target, g_bcnt, g_mcnt;
    logic [5:0]  g_index;

    int errors = 0;
    int checks = 0;

    int  m_bim [64];
    int  m_gs  [64];
    int  m_ghr = 0;
    int  m_bcnt = 0;
    int  m_mcnt = 0;
    bit  m_valid = 1'b0;

    localparam logic [31:0] BEQ = 32'h1000_0003;

    branch_predict_bht dut_bim (
        .clk(clk), .reset(reset), .pcF(pcF), .instrF(instrF),
        .is_branchF(b_is_branch), .predict_takenF(b_taken), .pc_predictF(b_target),
        .predict_indexF(b_index), .update_en(update_en), .update_index(update_index),
        .update_taken(update_taken), .update_pred(update_pred),
        .mispredictD(b_mispredict), .branch_cnt(b_bcnt), .mispredict_cnt(b_mcnt)
    );

    branch_predict_bht #(.GHR_BITS(2)) dut_gs (
        .clk(clk), .reset(reset), .pcF(pcF), .instrF(instrF),
        .is_branchF(g_is_branch), .predict_takenF(g_taken), .pc_predictF(g_target),
        .predict_indexF(g_index), .update_en(update_en), .update_index(update_index),
        .update_taken(update_taken), .update_pred(update_pred),
        .mispredictD(g_mispredict), .branch_cnt(g_bcnt), .mispredict_cnt(g_mcnt)
    );

    always #5 clk = ~clk;

    function automatic bit model_is_branch(input logic [31:0] ins);
        int op;
        int rt;
        op = int'(ins >> 26);
        rt = int'((ins >> 16) & 32'h1F);
        return (op >= 4 && op <= 7) || (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17));
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] ins);
        int off;
        off = int'($signed(ins[15:0]));
        return pc + 32'd4 + 32'(off * 4);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ins, input logic ue,
                                 input int ui, input logic ut, input logic up, input logic rst);
        @(posedge clk);
        #1;
        pcF          = pc;
        instrF       = ins;
        update_en    = ue;
        update_index = 6'(ui);
        update_taken = ut;
        update_pred  = up;
        reset        = rst;
    endtask

    // Reference model state advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                m_bim[i] = 1;
                m_gs[i]  = 1;
            end
            m_ghr   = 0;
            m_bcnt  = 0;
            m_mcnt  = 0;
            m_valid = 1'b1;
        end else if (update_en) begin
            if (update_taken) begin
                if (m_bim[update_index] < 3) m_bim[update_index]++;
                if (m_gs[update_index] < 3)  m_gs[update_index]++;
            end else begin
                if (m_bim[update_index] > 0) m_bim[update_index]--;
                if (m_gs[update_index] > 0)  m_gs[update_index]--;
            end
            m_ghr = ((m_ghr << 1) | int'(update_taken)) & 3;
            m_bcnt++;
            if (update_taken != update_pred) m_mcnt++;
        end
    end

    // Every falling edge, both instances are compared against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            bit          e_br;
            int          bi;
            int          gi;
            logic [31:0] e_tgt;
            logic        e_mis;
            e_br  = model_is_branch(instrF);
            bi    = int'((pcF >> 2) & 32'h3F);
            gi    = bi ^ m_ghr;
            e_tgt = model_target(pcF, instrF);
            e_mis = update_en && (update_taken != update_pred);
            checkOutput("bim is_branch", 32'(b_is_branch), 32'(e_br));
            checkOutput("bim taken", 32'(b_taken), 32'(e_br && m_bim[bi] >= 2));
            checkOutput("bim target", b_target, e_tgt);
            checkOutput("bim index", 32'(b_index), 32'(bi));
            checkOutput("bim mispredict", 32'(b_mispredict), 32'(e_mis));
            checkOutput("bim branch_cnt", b_bcnt, 32'(m_bcnt));
            checkOutput("bim mispredict_cnt", b_mcnt, 32'(m_mcnt));
            checkOutput("gs is_branch", 32'(g_is_branch), 32'(e_br));
            checkOutput("gs taken", 32'(g_taken), 32'(e_br && m_gs[gi] >= 2));
            checkOutput("gs target", g_target, e_tgt);
            checkOutput("gs index", 32'(g_index), 32'(gi));
            checkOutput("gs mispredict", 32'(g_mispredict), 32'(e_mis));
            checkOutput("gs branch_cnt", g_bcnt, 32'(m_bcnt));
            checkOutput("gs mispredict_cnt", g_mcnt, 32'(m_mcnt));
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int pulses;
        logic [1:0] preds [10];

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        applyStimulus(32'h0040_0000, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit reset beq is_branch", 32'(b_is_branch), 32'd1);
        checkOutput("lit reset beq taken", 32'(b_taken), 32'd0);
        checkOutput("lit reset beq target", b_target, 32'h0040_0010);
        checkOutput("lit reset branch_cnt", b_bcnt, 32'd0);

        applyStimulus(32'h0040_0100, 32'h0411_FFFF, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit bgezal is_branch", 32'(b_is_branch), 32'd1);
        checkOutput("lit bgezal target", b_target, 32'h0040_0100);

        for (int i = 0; i < 2; i++) applyStimulus(32'h0040_0000, BEQ, 1, 0, 1, 0, 0);
        applyStimulus(32'h0040_0000, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit sat two taken", 32'(b_taken), 32'd1);
        for (int i = 0; i < 5; i++) applyStimulus(32'h0040_0000, BEQ, 1, 0, 1, 0, 0);
        applyStimulus(32'h0040_0000, BEQ, 1, 0, 0, 1, 0);
        applyStimulus(32'h0040_0000, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit sat first not-taken", 32'(b_taken), 32'd1);
        applyStimulus(32'h0040_0000, BEQ, 1, 0, 0, 1, 0);
        applyStimulus(32'h0040_0000, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit sat second not-taken", 32'(b_taken), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(32'h0040_0000, BEQ, 1, 0, 0, 0, 0);
        applyStimulus(32'h0040_0000, BEQ, 1, 0, 1, 0, 0);
        applyStimulus(32'h0040_0000, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit sat floor then taken", 32'(b_taken), 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(32'h0000_0004, BEQ, 1, 1, 1, 0, 0);
        applyStimulus(32'h0000_0104, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit alias index", 32'(b_index), 32'd1);
        checkOutput("lit alias taken", 32'(b_taken), 32'd1);
        applyStimulus(32'h0000_0008, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit neighbour taken", 32'(b_taken), 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(32'h0000_0000, BEQ, 1, 0, 1, 0, 0);
        applyStimulus(32'h0000_000C, BEQ, 1, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("lit gshare index ghr11", 32'(g_index), 32'd0);
        checkOutput("lit gshare taken ghr11", 32'(g_taken), 32'd1);
        applyStimulus(32'h0000_0008, BEQ, 1, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("lit gshare index ghr10", 32'(g_index), 32'd0);
        checkOutput("lit gshare pre-update read", 32'(g_taken), 32'd1);
        applyStimulus(32'h0000_0000, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit gshare after two nt", 32'(g_taken), 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        preds = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h0000_0014, 32'h0800_0000, 1, 5, 1, preds[i][0], 0);
            @(negedge clk);
            #1;
            if (b_mispredict) pulses++;
        end
        applyStimulus(32'h0000_0014, 32'h0800_0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit stats branch_cnt", b_bcnt, 32'd10);
        checkOutput("lit stats mispredict_cnt", b_mcnt, 32'd3);
        checkOutput("lit stats mispredict pulses", 32'(pulses), 32'd3);
        checkOutput("lit jump is_branch", 32'(b_is_branch), 32'd0);
        checkOutput("lit jump taken", 32'(b_taken), 32'd0);

        applyStimulus(32'hFFFF_FFF0, 32'h1000_7FFF, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit target wrap", b_target, 32'h0001_FFF0);
        applyStimulus(32'h0000_0000, 32'h0402_0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit regimm rt2 not branch", 32'(b_is_branch), 32'd0);

        for (int op = 0; op < 64; op++) begin
            int rts [6];
            rts = '{0, 1, 2, 16, 17, 31};
            for (int r = 0; r < 6; r++) begin
                applyStimulus(32'(op * 4), {6'(op), 5'd3, 5'(rts[r]), 16'h0010}, 0, 0, 0, 0, 0);
            end
        end

        applyStimulus(32'h0000_0014, BEQ, 1, 5, 1, 0, 1);
        applyStimulus(32'h0000_0014, BEQ, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lit midreset taken", 32'(b_taken), 32'd0);
        checkOutput("lit midreset branch_cnt", b_bcnt, 32'd0);
        checkOutput("lit midreset mispredict_cnt", b_mcnt, 32'd0);
        checkOutput("lit midreset ghr cleared", 32'(g_index), 32'd5);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(32'(i * 4), BEQ, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("lit midreset bim entry", 32'(b_taken), 32'd0);
            checkOutput("lit midreset gs entry", 32'(g_taken), 32'd0);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
